uart_tx_scheduler: RTL and testbench

//   Shares one UART transmitter (8 data bits LSB first, 1 parity bit, 1 stop bit, idle-high line)

---
 rtl/uart_tx_scheduler_if.sv | 30 +++
 rtl/uart_tx_scheduler.sv | 149 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter bundle for uart_tx_scheduler.
// The slave modport is the scheduler's view; the master modport drives requests and tx_busy.
interface uart_tx_scheduler_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IdW = $clog2(N);

  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [15:0]    baudrate;
  logic [15:0]    baud_in;
  logic           baud_we;
  logic [IdW-1:0] grant_id;
  logic           active;
  logic           timeout;

  modport slave (
    input  req, req_data, tx_busy, baud_in, baud_we,
    output ack, tx_data, tx_start, baudrate, grant_id, active, timeout
  );

  modport master (
    output req, req_data, tx_busy, baud_in, baud_we,
    input  ack, tx_data, tx_start, baudrate, grant_id, active, timeout
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N byte requesters.
// Owns clocks-per-bit; baud writes land only while idle so a frame never changes rate.
module uart_tx_scheduler #(
  parameter int unsigned N            = 4,
  parameter int unsigned BAUD_DEFAULT = 8,
  parameter int unsigned GUARD_CYCLES = 8,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst,
  uart_tx_scheduler_if.slave bus
);
  localparam int unsigned IdW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone, StGuard} state_e;

  state_e         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] grant_q, grant_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic [15:0]    baud_q, baud_d;
  logic [15:0]    pend_val_q, pend_val_d;
  logic           pend_q, pend_d;
  logic           timeout_q, timeout_d;

  logic           baud_ok;
  logic           any_req;
  logic [IdW-1:0] sel;
  logic [IdW-1:0] cand;

  assign baud_ok = bus.baud_we && (bus.baud_in >= 16'd2);

  // Descending scan so the smallest rotation distance from the pointer wins.
  always_comb begin
    any_req = 1'b0;
    sel     = ptr_q;
    cand    = '0;
    for (int unsigned k = N; k > 0; k--) begin
      cand = IdW'((32'(ptr_q) + k - 1) % N);
      if (bus.req[cand]) begin
        any_req = 1'b1;
        sel     = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    baud_d     = baud_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    timeout_d  = timeout_q;

    if (state_q != StIdle && baud_ok) begin
      pend_d     = 1'b1;
      pend_val_d = bus.baud_in;
    end

    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          baud_d = baud_ok ? bus.baud_in : pend_val_q;
          pend_d = 1'b0;
        end else if (baud_ok) begin
          baud_d = bus.baud_in;
        end else if (any_req) begin
          tx_data_d  = 8'(bus.req_data >> {sel, 3'b000});
          grant_d    = sel;
          ack_d[sel] = 1'b1;
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (bus.tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == 16'(BUSY_TIMEOUT - 1)) begin
          // Byte is dropped, not retried.
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StGuard;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          cnt_d   = '0;
          state_d = StGuard;
        end
      end
      StGuard: begin
        if (cnt_q == 16'(GUARD_CYCLES - 1)) begin
          ptr_d   = (grant_q == IdW'(N - 1)) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      baud_q     <= 16'(BAUD_DEFAULT);
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      baud_q     <= baud_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.baudrate = baud_q;
  assign bus.grant_id = grant_q;
  assign bus.active   = (state_q != StIdle);
  assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus random batches, with a grant
// scoreboard fed by a round-robin reference model and a behavioural transmitter.
module tb_uart_tx_scheduler;
  localparam int unsigned N            = 4;
  localparam int unsigned BAUD_DEFAULT = 8;
  localparam int unsigned GUARD_CYCLES = 8;
  localparam int unsigned BUSY_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.N(N)) bus ();

  uart_tx_scheduler #(
    .N           (N),
    .BAUD_DEFAULT(BAUD_DEFAULT),
    .GUARD_CYCLES(GUARD_CYCLES),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int unsigned id;
    logic [7:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned model_ptr;
  logic [15:0] model_baud;
  bit          auto_drop;
  bit          busy_en;
  int unsigned dly_max;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bad(input string name);
    n_checks++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  // Reference arbiter: first set request at or after the pointer, wrapping.
  function automatic int unsigned pick(input logic [N-1:0] r);
    int unsigned idx;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (model_ptr + k) % N;
      if (((r >> idx) & N'(1)) != '0) return idx;
    end
    return 0;
  endfunction

  task automatic expect_batch(input logic [N-1:0] set, input int unsigned count, input bit drop);
    exp_t        e;
    int unsigned id;
    for (int unsigned j = 0; j < count; j++) begin
      id     = pick(set);
      e.id   = id;
      e.data = 8'(bus.req_data >> (8 * id));
      exp_q.push_back(e);
      model_ptr = (id + 1) % N;
      if (drop) set = set & ~(N'(1) << id);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_drop) bus.req = bus.req & ~bus.ack;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    model_ptr  = 0;
    model_baud = 16'(BAUD_DEFAULT);
  endtask

  task automatic pulse_baud(input logic [15:0] v);
    bus.baud_in = v;
    bus.baud_we = 1'b1;
    step();
    bus.baud_we = 1'b0;
    if (v >= 16'd2) model_baud = v;
  endtask

  task automatic wait_busy(input logic v, input int unsigned bound, input string name);
    int unsigned n = 0;
    while (bus.tx_busy !== v && n < bound) begin
      step();
      n++;
    end
    if (bus.tx_busy !== v) bad(name);
  endtask

  task automatic wait_idle(input int unsigned bound, input string name);
    int unsigned n = 0;
    while (!(bus.req == '0 && !bus.active && exp_q.size() == 0) && n < bound) begin
      step();
      n++;
    end
    if (bus.req != '0 || bus.active || exp_q.size() != 0) bad(name);
  endtask

  // Transmitter: busy rises 0..dly_max cycles after tx_start, lasts 11 bit times.
  initial begin : xmtr
    int unsigned d;
    int unsigned len;
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.tx_start === 1'b1 && busy_en && !rst) begin
        d   = $urandom_range(0, dly_max);
        len = 11 * 32'(bus.baudrate);
        for (int unsigned k = 0; k < d; k++) begin
          @(posedge clk);
          #2;
        end
        bus.tx_busy = 1'b1;
        for (int unsigned k = 0; k < len; k++) begin
          @(posedge clk);
          #2;
        end
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every grant and checks frame-level invariants.
  bit          prev_start, prev_busy, frame_open, have_fall;
  int unsigned fall_cyc;
  logic [7:0]  start_data;
  logic [15:0] start_baud;

  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
      frame_open = 1'b0;
      have_fall  = 1'b0;
      prev_busy  = bus.tx_busy;
    end else begin
      if (bus.tx_start === 1'b1 || (bus.ack !== '0 && !$isunknown(bus.ack))) begin
        chk("start_with_ack", 32'(bus.tx_start), 32'd1);
        if (exp_q.size() == 0) begin
          bad("unexpected_grant");
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_id", 32'(bus.grant_id), mon_e.id);
          chk("tx_data", 32'(bus.tx_data), 32'(mon_e.data));
          chk("ack_onehot", 32'(bus.ack), 32'(N'(1) << mon_e.id));
        end
        chk("start_not_consecutive", 32'(prev_start), 32'd0);
        if (have_fall) chk("guard_gap", 32'(cyc - fall_cyc >= GUARD_CYCLES), 32'd1);
        start_data = bus.tx_data;
        start_baud = bus.baudrate;
        frame_open = 1'b1;
      end
      if (prev_busy && !bus.tx_busy && frame_open) begin
        chk("tx_data_stable", 32'(bus.tx_data), 32'(start_data));
        chk("baud_stable_in_frame", 32'(bus.baudrate), 32'(start_baud));
        have_fall  = 1'b1;
        fall_cyc   = cyc;
        frame_open = 1'b0;
      end
      prev_start = bus.tx_start;
      prev_busy  = bus.tx_busy;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned n, g, cb, cs, mid_bad, wcyc;
    logic [N-1:0] set;
    logic [15:0]  bv;

    rst          = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.baud_in  = '0;
    bus.baud_we  = 1'b0;
    auto_drop    = 1'b0;
    busy_en      = 1'b1;
    dly_max      = 0;
    step();
    do_reset();
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_baud", 32'(bus.baudrate), BAUD_DEFAULT);

    // Single request, one-cycle grant latency, guard timing.
    auto_drop    = 1'b1;
    bus.req_data = 32'h0000_0055;
    expect_batch(4'b0001, 1, 1'b1);
    bus.req = 4'b0001;
    step();
    chk("t1_ack", 32'(bus.ack), 32'h1);
    chk("t1_start", 32'(bus.tx_start), 32'd1);
    chk("t1_data", 32'(bus.tx_data), 32'h55);
    step();
    chk("t1_ack_pulse", 32'(bus.ack), 32'd0);
    chk("t1_start_pulse", 32'(bus.tx_start), 32'd0);
    wait_busy(1'b1, 10, "t1_busy_rise");
    wait_busy(1'b0, 200, "t1_busy_fall");
    repeat (GUARD_CYCLES - 1) step();
    chk("t1_active_in_guard", 32'(bus.active), 32'd1);
    step();
    chk("t1_active_low", 32'(bus.active), 32'd0);

    // All four held: rotation 0,1,2,3,0.
    do_reset();
    auto_drop    = 1'b0;
    bus.req_data = 32'h4433_2211;
    expect_batch(4'b1111, 5, 1'b0);
    bus.req = 4'b1111;
    n = 0;
    g = 0;
    while (g < 5 && n < 1000) begin
      step();
      if (bus.tx_start) g++;
      n++;
    end
    if (g < 5) bad("t2_five_grants");
    bus.req = '0;
    wait_idle(300, "t2_idle");

    // Baud write mid-frame is deferred to the first idle cycle.
    do_reset();
    auto_drop    = 1'b1;
    bus.req_data = $urandom();
    expect_batch(4'b0001, 1, 1'b1);
    bus.req = 4'b0001;
    wait_busy(1'b1, 10, "t3_busy_rise");
    repeat (5) step();
    bus.req = bus.req | 4'b0100;
    expect_batch(4'b0100, 1, 1'b1);
    pulse_baud(16'd16);
    cb = 0;
    cs = 0;
    mid_bad = 0;
    n = 0;
    while (cs == 0 && n < 300) begin
      step();
      n++;
      if (cb == 0 && bus.baudrate == 16'd16) begin
        cb = cyc;
        chk("t3_baud_applied_idle", 32'(bus.active), 32'd0);
      end else if (cb == 0 && bus.baudrate != 16'd8) begin
        mid_bad++;
      end
      if (cb != 0 && bus.tx_start) cs = cyc;
    end
    chk("t3_baud_held", mid_bad, 32'd0);
    if (cb == 0) bad("t3_baud_never_applied");
    else chk("t3_start_after_baud", cs, cb + 1);
    wait_idle(400, "t3_idle");

    // Ignored values, minimum legal value, baud beats a simultaneous request.
    do_reset();
    pulse_baud(16'd1);
    chk("t4_baud_1_ignored", 32'(bus.baudrate), 32'd8);
    pulse_baud(16'd0);
    chk("t4_baud_0_ignored", 32'(bus.baudrate), 32'd8);
    pulse_baud(16'd2);
    chk("t4_baud_2_applied", 32'(bus.baudrate), 32'd2);
    auto_drop    = 1'b1;
    bus.req_data = $urandom();
    expect_batch(4'b1000, 1, 1'b1);
    bus.req     = 4'b1000;
    bus.baud_in = 16'd9;
    bus.baud_we = 1'b1;
    step();
    bus.baud_we = 1'b0;
    model_baud  = 16'd9;
    chk("t4_baud_wins", 32'(bus.baudrate), 32'd9);
    chk("t4_no_start_yet", 32'(bus.tx_start), 32'd0);
    step();
    chk("t4_start_next", 32'(bus.tx_start), 32'd1);
    wait_idle(300, "t4_idle");

    // tx_busy never rises: timeout, guard, regrant of the held requester.
    busy_en      = 1'b0;
    auto_drop    = 1'b0;
    bus.req_data = $urandom();
    expect_batch(4'b0010, 2, 1'b0);
    bus.req = 4'b0010;
    n = 0;
    while (bus.tx_start !== 1'b1 && n < 5) begin
      step();
      n++;
    end
    if (bus.tx_start !== 1'b1) bad("t5_first_grant");
    repeat (BUSY_TIMEOUT - 1) step();
    chk("t5_timeout_early", 32'(bus.timeout), 32'd0);
    step();
    chk("t5_timeout_set", 32'(bus.timeout), 32'd1);
    chk("t5_guard_active", 32'(bus.active), 32'd1);
    repeat (GUARD_CYCLES - 1) step();
    chk("t5_guard_end_active", 32'(bus.active), 32'd1);
    step();
    chk("t5_idle", 32'(bus.active), 32'd0);
    step();
    chk("t5_regrant", 32'(bus.tx_start), 32'd1);
    chk("t5_sticky", 32'(bus.timeout), 32'd1);
    bus.req = '0;
    wait_idle(60, "t5_idle_after");
    busy_en = 1'b1;
    chk("t5_sticky_after", 32'(bus.timeout), 32'd1);

    // Random batches with a random baud write somewhere in each.
    dly_max   = 3;
    auto_drop = 1'b1;
    for (int it = 0; it < 10; it++) begin
      set          = N'($urandom_range(1, (1 << N) - 1));
      bus.req_data = $urandom();
      expect_batch(set, $countones(set), 1'b1);
      wcyc = $urandom_range(0, 80);
      case ($urandom_range(0, 3))
        0:       bv = 16'd0;
        1:       bv = 16'd1;
        default: bv = 16'($urandom_range(2, 12));
      endcase
      bus.req = set;
      n = 0;
      while (!(bus.req == '0 && !bus.active && exp_q.size() == 0) && n < 3000) begin
        if (n == wcyc) begin
          bus.baud_in = bv;
          bus.baud_we = 1'b1;
          if (bv >= 16'd2) model_baud = bv;
        end
        step();
        bus.baud_we = 1'b0;
        n++;
      end
      if (bus.req != '0 || bus.active || exp_q.size() != 0) bad("rnd_batch_done");
      step();
      chk("rnd_baud", 32'(bus.baudrate), 32'(model_baud));
    end
    dly_max = 0;

    // Reset mid-frame with a pending baud write and sticky timeout set.
    bus.req_data = $urandom();
    expect_batch(4'b0100, 1, 1'b1);
    bus.req = 4'b0100;
    wait_busy(1'b1, 10, "t6_busy_rise");
    repeat (3) step();
    pulse_baud(16'd20);
    do_reset();
    chk("t6_ack", 32'(bus.ack), 32'd0);
    chk("t6_tx_start", 32'(bus.tx_start), 32'd0);
    chk("t6_tx_data", 32'(bus.tx_data), 32'd0);
    chk("t6_grant_id", 32'(bus.grant_id), 32'd0);
    chk("t6_active", 32'(bus.active), 32'd0);
    chk("t6_timeout", 32'(bus.timeout), 32'd0);
    chk("t6_baud", 32'(bus.baudrate), 32'd8);
    repeat (3) step();
    chk("t6_pending_dropped", 32'(bus.baudrate), 32'd8);
    wait_busy(1'b0, 300, "t6_old_frame_end");
    bus.req_data = $urandom();
    expect_batch(4'b1111, 4, 1'b1);
    bus.req = 4'b1111;
    wait_idle(1500, "t6_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
